spi_master_param: RTL
=====================

SPI_MASTER_PARAM -- requirements
Module: spi_master_param

Interface
REQ-001 Parameter DATA_W, default 8: bits per transfer; legal range 4..32.
REQ-002 Parameter NCS, default 1: number of chip-select lines; legal range 1..8.
REQ-003 Parameter DIV_W, default 10: width of the runtime divider input.
REQ-004 CLK  in  1  system clock; all state changes on its rising edge.
REQ-005 RST  in  1  asynchronous, active-high reset.
REQ-006 DIV  in  DIV_W  CLK cycles per SCLK half-period; the value 0 is treated as 1.
REQ-007 CPOL  in  1  SCLK idle level.
REQ-008 CPHA  in  1  0 = sample on leading edge, shift on trailing edge; 1 = shift on leading edge, sample on trailing edge.
REQ-009 LSB_FIRST  in  1  0 = MSB first, 1 = LSB first.
REQ-010 CS_SEL  in  clog2(NCS) (min 1)  index of the target slave.
REQ-011 W_STB  in  1  one-cycle request to start a transfer with W_DATA.
REQ-012 W_DATA  in  DATA_W  transmit word.
REQ-013 W_READY  out  1  high while the block is idle and able to accept W_STB.
REQ-014 R_STB  out  1  one-cycle pulse that marks R_DATA as valid.
REQ-015 R_DATA  out  DATA_W  received word; held stable until the next R_STB.
REQ-016 SCLK  out  1  serial clock.
REQ-017 MOSI  out  1  serial data out.
REQ-018 MISO  in  1  serial data in.
REQ-019 CS_N  out  NCS  active-low chip selects.

Function
REQ-020 The FSM SHALL have the states IDLE, LEAD, XFER and TRAIL.
REQ-021 IDLE SHALL accept W_STB only when W_READY=1; W_STB while busy SHALL be ignored with no side effects.
- On acceptance, latch W_DATA, CPOL, CPHA, LSB_FIRST, CS_SEL and DIV.
- W_READY SHALL go low the next cycle.
REQ-022 A half-period tick SHALL occur every DIV latched CLK cycles, counted from the acceptance edge.
REQ-023 LEAD SHALL last one half-period.
- CS_N[CS_SEL] low from the cycle after acceptance.
- SCLK stays at CPOL.
- When CPHA=0, the first data bit is on MOSI at LEAD entry.
REQ-024 XFER SHALL last exactly 2*DATA_W half-periods, with one SCLK toggle per tick.
- The shift edge SHALL drive the next bit to MOSI.
- The sample edge SHALL capture MISO into the shift register.
REQ-025 TRAIL SHALL last one half-period with SCLK=CPOL and CS_N still asserted; CS_N SHALL then return to all ones on entry to IDLE.
REQ-026 R_STB SHALL pulse in the cycle of entry to IDLE, i.e. (2*DATA_W+2)*DIV CLK cycles after the acceptance edge.
- R_DATA SHALL update in the same cycle.
- W_READY SHALL be high in the same cycle.
REQ-027 W_STB in the same cycle as R_STB SHALL be accepted, giving back-to-back transfers with CS_N deasserted for at least one CLK cycle.
REQ-028 Bit order SHALL be applied identically to MOSI and R_DATA: MSB first unless LSB_FIRST.
REQ-029 Changes on DIV, CPOL, CPHA, LSB_FIRST and CS_SEL during a transfer SHALL have no effect until the next acceptance.
REQ-030 In IDLE, SCLK SHALL follow the live CPOL input and MOSI SHALL be 0.
REQ-031 Out-of-range CS_SEL (>= NCS) SHALL run the transfer with no CS_N asserted.

Reset
REQ-032 Reset SHALL place the block in IDLE with:
- SCLK = CPOL input
- MOSI = 0
- CS_N = all ones
- W_READY = 1
- R_STB = 0
- R_DATA = 0
- all counters cleared
REQ-033 Reset asserted mid-transfer SHALL abort it immediately, with no R_STB.

Structure
REQ-034 A shared package spi_pkg SHALL hold the state encoding (IDLE/LEAD/XFER/TRAIL) and the mode constants (MODE0..MODE3 as {CPOL,CPHA}).
REQ-035 A single sub-module spi_tick_gen (DIV_W-bit down-counter, reload on tick or start) SHALL generate the half-period ticks.

Verification
REQ-036 DATA_W=8, DIV=5, mode 0, MSB first, W_DATA=0x55, MISO serialising 0x29:
- MOSI = 0,1,0,1,0,1,0,1 on successive rising SCLK edges
- 8 rising SCLK edges
- R_STB 90 CLK cycles after acceptance
- R_DATA = 0x29
REQ-037 Repeat REQ-036 in modes 1, 2 and 3: SCLK idles at CPOL, sampling is on the correct edge, R_DATA = 0x29 in every mode.
REQ-038 DATA_W=16, LSB_FIRST=1, W_DATA=0x8001, MISO 0x6329 sent LSB first:
- MOSI first bit 1, last bit 1
- R_DATA = 0x6329
REQ-039 NCS=4, CS_SEL=2, W_STB pulsed in the R_STB cycle:
- only CS_N[2] goes low
- second transfer starts with a 1-cycle CS_N gap
- a W_STB during XFER is ignored
REQ-040 RST pulsed during XFER (bit 3):
- CS_N = 1111 and W_READY = 1 immediately
- no R_STB
- next transfer completes normally
REQ-041 DIV=0 behaves as DIV=1: R_STB 18 cycles after acceptance for DATA_W=8.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding and the four {CPOL,CPHA} modes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        XFER  = 2'd2,
        TRAIL = 2'd3
    } spi_state_t;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period tick generator: down-counter reloaded on start or on every tick.
// Latency: first tick exactly `load` CLK cycles after the start edge, then every `load` cycles.
// Backpressure: none; counts freely while enabled, holds while disabled.
module spi_tick_gen #(
    parameter int DIV_W = 10
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             en,
    input  logic [DIV_W-1:0] load,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    assign tick = en && (cnt == '0);

    // Reload on start or tick so each tick lands exactly `load` cycles after the previous event.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= '0;
        end else if (start || tick) begin
            cnt <= load - DIV_W'(1);
        end else if (en) begin
            cnt <= cnt - DIV_W'(1);
        end
    end

endmodule

// File: rtl/spi_master_param.sv
// Parameterised SPI master: one DATA_W-bit full-duplex transfer per accepted W_STB, all four modes.
// Latency: R_STB (2*DATA_W+2)*DIV CLK cycles after the accepting edge (DIV of 0 counts as 1).
// Backpressure: W_READY low from the cycle after acceptance until the R_STB cycle; W_STB while busy is dropped.
module spi_master_param
    import spi_pkg::*;
#(
    parameter int  DATA_W = 8,
    parameter int  NCS    = 1,
    parameter int  DIV_W  = 10,
    localparam int CS_W   = (NCS > 1) ? $clog2(NCS) : 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DIV_W-1:0]  DIV,
    input  logic              CPOL,
    input  logic              CPHA,
    input  logic              LSB_FIRST,
    input  logic [CS_W-1:0]   CS_SEL,
    input  logic              W_STB,
    input  logic [DATA_W-1:0] W_DATA,
    output logic              W_READY,
    output logic              R_STB,
    output logic [DATA_W-1:0] R_DATA,
    output logic              SCLK,
    output logic              MOSI,
    input  logic              MISO,
    output logic [NCS-1:0]    CS_N
);

    localparam int CNT_W = $clog2(2 * DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_HALF = CNT_W'(2 * DATA_W - 1);

    spi_state_t state_q, state_d;

    logic              accept;
    logic              tick;
    logic [DIV_W-1:0]  div_live;
    logic [DIV_W-1:0]  div_l;
    logic              cpol_l, cpha_l, lsb_l;
    logic [DATA_W-1:0] tx_q, rx_q;
    logic [CNT_W-1:0]  hcnt;
    logic              sclk_q, mosi_q;
    logic [NCS-1:0]    cs_n_q, cs_mask;
    logic              r_stb_q;
    logic [DATA_W-1:0] r_data_q;
    logic              edge_evt, leading, shift_edge, sample_edge;

    function automatic logic head_bit(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? w[0] : w[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? (w >> 1) : (w << 1);
    endfunction

    assign accept   = W_STB && (state_q == IDLE);
    assign div_live = (DIV == '0) ? DIV_W'(1) : DIV;

    // hcnt counts completed SCLK toggles; even count means the next toggle is a leading edge.
    assign edge_evt    = (state_q == XFER) && tick;
    assign leading     = ~hcnt[0];
    assign shift_edge  = edge_evt && (cpha_l ? leading : ~leading);
    assign sample_edge = edge_evt && (cpha_l ? ~leading : leading);

    spi_tick_gen #(.DIV_W(DIV_W)) u_tick (
        .CLK   (CLK),
        .RST   (RST),
        .start (accept),
        .en    (state_q != IDLE),
        .load  (accept ? div_live : div_l),
        .tick  (tick)
    );

    // One-hot active-low select; an out-of-range index matches nothing, so no line asserts.
    always_comb begin
        cs_mask = '1;
        for (int i = 0; i < NCS; i++) begin
            if (CS_SEL == CS_W'(i)) cs_mask[i] = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state: each non-idle phase advances only on a half-period tick.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = LEAD;
            LEAD:    if (tick) state_d = XFER;
            XFER:    if (tick && (hcnt == LAST_HALF)) state_d = TRAIL;
            TRAIL:   if (tick) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: latch the request, toggle SCLK, shift MOSI / sample MISO, publish the result.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            div_l    <= '0;
            cpol_l   <= 1'b0;
            cpha_l   <= 1'b0;
            lsb_l    <= 1'b0;
            tx_q     <= '0;
            rx_q     <= '0;
            hcnt     <= '0;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            cs_n_q   <= '1;
            r_stb_q  <= 1'b0;
            r_data_q <= '0;
        end else begin
            r_stb_q <= 1'b0;
            if (accept) begin
                div_l  <= div_live;
                cpol_l <= CPOL;
                cpha_l <= CPHA;
                lsb_l  <= LSB_FIRST;
                sclk_q <= CPOL;
                hcnt   <= '0;
                rx_q   <= '0;
                cs_n_q <= cs_mask;
                // CPHA=0 needs bit 0 on the wire before the first (sampling) edge.
                if (CPHA) begin
                    tx_q   <= W_DATA;
                    mosi_q <= 1'b0;
                end else begin
                    tx_q   <= shift_out(W_DATA, LSB_FIRST);
                    mosi_q <= head_bit(W_DATA, LSB_FIRST);
                end
            end else begin
                if (edge_evt) begin
                    sclk_q <= ~sclk_q;
                    hcnt   <= hcnt + CNT_W'(1);
                end
                if (shift_edge) begin
                    mosi_q <= head_bit(tx_q, lsb_l);
                    tx_q   <= shift_out(tx_q, lsb_l);
                end
                if (sample_edge) begin
                    rx_q <= lsb_l ? {MISO, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], MISO};
                end
                if ((state_q == TRAIL) && tick) begin
                    cs_n_q   <= '1;
                    r_stb_q  <= 1'b1;
                    r_data_q <= rx_q;
                end
            end
        end
    end

    assign W_READY = (state_q == IDLE);
    assign R_STB   = r_stb_q;
    assign R_DATA  = r_data_q;
    assign SCLK    = (state_q == IDLE) ? CPOL : sclk_q;
    assign MOSI    = (state_q == IDLE) ? 1'b0 : mosi_q;
    assign CS_N    = cs_n_q;

endmodule
